// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_pkg
// Description : Shared card types, constants and dealer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_BLANK   = 4'd0;
    localparam card_t CARD_ACE     = 4'd1;
    localparam card_t CARD_KING    = 4'd13;

    localparam int    PLAYER_SLOTS = 3;
    localparam int    DEALER_SLOTS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        ACK  = 2'd2
    } dealer_state_t;

endpackage
`default_nettype wire

// File: rtl/card_dealer_if.sv
`default_nettype none
// ============================================================================
// Module      : card_dealer_if
// Description : Deal request/acknowledge handshake and slot read-out bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface card_dealer_if #(
    parameter int NUM_SLOTS = 6
);
    logic                   deal_req;
    logic [2:0]             slot_sel;
    logic                   clear_hands;
    logic                   deal_ack;
    logic                   deal_err;
    logic                   busy;
    logic [3:0]             last_card;
    logic [NUM_SLOTS*4-1:0] cards;

    modport master (
        output deal_req, slot_sel, clear_hands,
        input  deal_ack, deal_err, busy, last_card, cards
    );

    modport slave (
        input  deal_req, slot_sel, clear_hands,
        output deal_ack, deal_err, busy, last_card, cards
    );
endinterface
`default_nettype wire

// File: rtl/card_counter.sv
`default_nettype none
// ============================================================================
// Module      : card_counter
// Description : Free-running modulo counter cycling CARD_MIN..CARD_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module card_counter #(
    parameter int CARD_MIN = 1,
    parameter int CARD_MAX = 13
) (
    input  wire logic       clk,
    input  wire logic       resetb,
    output logic [3:0]      o_count
);
    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_count <= 4'(CARD_MIN);
        end else if (r_count >= 4'(CARD_MAX)) begin
            r_count <= 4'(CARD_MIN);
        end else begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
// Module      : card_dealer
// Description : Snapshots the shuffle counter into hand slots on a 4-phase deal.
// Revision    : 1.0 - initial release
// ============================================================================
module card_dealer
    import card_pkg::*;
#(
    parameter int NUM_SLOTS = 6,
    parameter int CARD_MIN  = 1,
    parameter int CARD_MAX  = 13
) (
    input  wire logic     clk,
    input  wire logic     resetb,
    card_dealer_if.slave  bus
);
    dealer_state_t r_state;
    card_t         r_slots [NUM_SLOTS];
    card_t         r_last_card;
    logic [2:0]    r_slot_q;
    logic          r_ack;
    logic          r_err;
    logic          r_busy;
    card_t         w_count;
    logic          w_writable;

    card_counter #(
        .CARD_MIN (CARD_MIN),
        .CARD_MAX (CARD_MAX)
    ) u_counter (
        .clk     (clk),
        .resetb  (resetb),
        .o_count (w_count)
    );

    // Out-of-range indices match no slot, so they fall out as not writable.
    always_comb begin
        w_writable = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slot_q == 3'(i) && r_slots[i] == CARD_BLANK) begin
                w_writable = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state     <= IDLE;
            r_last_card <= CARD_BLANK;
            r_slot_q    <= 3'd0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots[i] <= CARD_BLANK;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clear_hands) begin
                        r_last_card <= CARD_BLANK;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            r_slots[i] <= CARD_BLANK;
                        end
                    end else if (bus.deal_req) begin
                        r_slot_q <= bus.slot_sel;
                        r_busy   <= 1'b1;
                        r_state  <= DRAW;
                    end
                end
                DRAW: begin
                    if (w_writable) begin
                        r_last_card <= w_count;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (r_slot_q == 3'(i)) begin
                                r_slots[i] <= w_count;
                            end
                        end
                    end
                    r_err   <= !w_writable;
                    r_ack   <= 1'b1;
                    r_state <= ACK;
                end
                ACK: begin
                    if (!bus.deal_req) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_cards
        assign bus.cards[4*g +: 4] = r_slots[g];
    end

    assign bus.deal_ack  = r_ack;
    assign bus.deal_err  = r_err;
    assign bus.busy      = r_busy;
    assign bus.last_card = r_last_card;
endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_dealer
// Description : Randomized self-checking bench for card_dealer with a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_dealer;
    logic clk;
    logic resetb;
    int   n_cmp;
    int   n_err;
    int   n_edges;
    int   m_slots [6];
    int   m_last;

    card_dealer_if #(.NUM_SLOTS(6)) bus ();

    card_dealer #(.NUM_SLOTS(6), .CARD_MIN(1), .CARD_MAX(13)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter value in the current cycle = edges since reset, mod 13, plus one.
    function automatic int cnt();
        return (n_edges % 13) + 1;
    endfunction

    function automatic logic [31:0] exp_cards();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'(m_slots[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetb) n_edges++;
        else        n_edges = 0;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++) m_slots[i] = 0;
        m_last = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ack"},   32'(bus.deal_ack), 0);
        check({tag, "_err"},   32'(bus.deal_err), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_cards"}, 32'(bus.cards), exp_cards());
        check({tag, "_last"},  32'(bus.last_card), 32'(m_last));
    endtask

    task automatic do_clear(input logic with_req);
        bus.clear_hands = 1'b1;
        bus.deal_req    = with_req;
        bus.slot_sel    = 3'd0;
        tick();
        model_clear();
        check_idle("clear");
        bus.clear_hands = 1'b0;
        bus.deal_req    = 1'b0;
    endtask

    task automatic do_deal(input int s, input int hold);
        int  v;
        bit  ok;
        bus.deal_req = 1'b1;
        bus.slot_sel = 3'(s);
        tick();
        v = cnt();
        check("draw_busy", 32'(bus.busy), 1);
        check("draw_ack",  32'(bus.deal_ack), 0);
        ok = (s < 6) && (m_slots[s] == 0);
        if (ok) begin
            m_slots[s] = v;
            m_last     = v;
        end
        bus.slot_sel = 3'($urandom_range(7));
        tick();
        check("ack_ack",   32'(bus.deal_ack), 1);
        check("ack_err",   32'(bus.deal_err), 32'(!ok));
        check("ack_cards", 32'(bus.cards), exp_cards());
        check("ack_last",  32'(bus.last_card), 32'(m_last));
        for (int h = 0; h < hold; h++) begin
            bus.clear_hands = 1'($urandom_range(1));
            tick();
            check("hold_ack",   32'(bus.deal_ack), 1);
            check("hold_err",   32'(bus.deal_err), 32'(!ok));
            check("hold_cards", 32'(bus.cards), exp_cards());
        end
        bus.deal_req    = 1'b0;
        bus.clear_hands = 1'b0;
        tick();
        check_idle("release");
    endtask

    task automatic wait_cnt(input int target);
        int guard;
        guard = 0;
        while (cnt() != target && guard < 20) begin
            tick();
            guard++;
        end
        check("wait_cnt", 32'(cnt()), 32'(target));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_edges = 0;
        resetb = 1'b0;
        bus.deal_req = 1'b0; bus.slot_sel = 3'd0; bus.clear_hands = 1'b0;
        model_clear();

        tick(); tick();
        check_idle("reset");
        resetb = 1'b1;

        do_deal(0, 0);
        check("basic_last", 32'(bus.last_card), 2);

        do_deal(0, 1);
        check("occupied_slot0", 32'(bus.cards[3:0]), 2);
        do_deal(6, 0);
        do_deal(7, 0);

        for (int s = 1; s < 6; s++) do_deal(s, 0);
        do_clear(1'b1);
        bus.deal_req = 1'b1;
        do_deal(0, 0);

        do_clear(1'b0);
        wait_cnt(12);
        do_deal(0, 0);
        check("wrap_13", 32'(bus.last_card), 13);
        wait_cnt(13);
        do_deal(1, 0);
        check("wrap_1", 32'(bus.last_card), 1);

        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(9);
            if (r == 0) do_clear($urandom_range(1) == 1);
            else if (r == 1) tick();
            else do_deal($urandom_range(7), $urandom_range(2));
        end

        bus.deal_req = 1'b1; bus.slot_sel = 3'd2;
        do_clear(1'b0);
        bus.deal_req = 1'b1;
        tick(); tick();
        check("mid_ack_pre", 32'(bus.deal_ack), 1);
        resetb = 1'b0;
        tick();
        model_clear();
        check_idle("mid_reset");
        resetb = 1'b1;
        bus.deal_req = 1'b0;
        do_deal(0, 0);
        check("post_reset_cnt", 32'(bus.last_card), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Upstream stage of the card display path. Holds a free-running modulo-13 "shuffle" counter and a bank of hand-slot registers (3 player, 3 dealer). On a 4-phase request/acknowledge handshake it snapshots the counter value into the selected slot. Each slot output drives one card7seg decoder directly: 0 = blank, 1..13 = A..K.

Parameters:
NUM_SLOTS, 6, number of 4-bit card slots (slots 0-2 player, 3-5 dealer)
CARD_MIN, 1, lowest dealt value (Ace)
CARD_MAX, 13, highest dealt value (King)

Ports:
clk  input  1  single system clock, rising-edge
resetb  input  1  synchronous active-low reset
deal_req  input  1  deal request, 4-phase handshake (held until deal_ack seen)
slot_sel  input  3  target slot, sampled only on request acceptance
clear_hands  input  1  clear all slots to blank; honoured only in IDLE
deal_ack  output  1  handshake acknowledge, held until deal_req drops
deal_err  output  1  valid only while deal_ack=1: request rejected (bad or occupied slot)
busy  output  1  high whenever state != IDLE
last_card  output  4  value captured by the most recent successful deal
cards  output  NUM_SLOTS x 4  packed slot contents, slot i at bits [4i+3:4i]

Behaviour:
- Reset (resetb=0 at a rising edge):
  - counter = 1, state = IDLE, all slots = 0
  - last_card = 0, deal_ack = 0, deal_err = 0, busy = 0
  - Reset overrides everything in any state, including mid-handshake.
- Counter:
  - Increments every cycle resetb=1, independent of FSM state.
  - Wraps 13 -> 1. Never holds 0, 14 or 15.
- FSM states: IDLE, DRAW, ACK.
- IDLE:
  - If clear_hands=1: all slots <= 0 and last_card <= 0 next edge; stay IDLE. clear_hands has priority over a simultaneous deal_req.
  - Else if deal_req=1: latch slot_sel into slot_q; -> DRAW.
- DRAW (exactly one cycle):
  - If slot_q >= NUM_SLOTS or slot[slot_q] != 0: no write, err_q <= 1.
  - Else slot[slot_q] <= counter value present during the DRAW cycle; last_card <= same value; err_q <= 0.
  - -> ACK.
- ACK:
  - deal_ack = 1, deal_err = err_q (both registered outputs).
  - Stay while deal_req=1. When deal_req=0 -> IDLE next edge; deal_ack/deal_err return to 0 that edge.
- Latency: request accepted at edge E -> slot written at E+1 -> deal_ack visible in the cycle after E+1.
- clear_hands in DRAW/ACK is ignored; it is not queued.
- slot_sel changes after acceptance have no effect.
- cards/last_card are register outputs only; no combinational path from inputs.

Decomposition:
- Package card_pkg:
  - card_t (logic [3:0])
  - CARD_BLANK=0, CARD_ACE=1, CARD_KING=13
  - dealer_state_t enum {IDLE, DRAW, ACK}
  - PLAYER_SLOTS=3, DEALER_SLOTS=3
- Sub-module card_counter: modulo counter CARD_MIN..CARD_MAX with synchronous active-low reset and 4-bit output. Instantiated once; reused later by the scoring stage's bench.

Test Plan:
- Reset release: resetb low 2 cycles, then high -> cards all 0, deal_ack=0, busy=0; counter reads 1,2,...,13,1 over 14 cycles.
- Basic deal: first post-reset cycle (counter=1) deal_req=1, slot_sel=0 -> cards[3:0]=2 after DRAW; deal_ack=1 next cycle, deal_err=0; drop deal_req -> deal_ack=0 next edge, busy=0.
- Occupied slot: after basic deal, second request to slot 0 -> deal_ack=1, deal_err=1, cards[3:0] still 2, last_card unchanged. Bad index: slot_sel=6 -> deal_err=1, no slot changes.
- Clear priority: six slots dealt; in IDLE assert clear_hands=1 and deal_req=1 together -> all cards=0, last_card=0, FSM stays IDLE, no ack that cycle; request served on the following cycle.
- Wrap: accept request when counter=12 -> DRAW captures 13; next request timed so counter=13 at acceptance -> captures 1, never 0.
- Mid-handshake reset: resetb=0 while in ACK with deal_ack=1 -> next edge deal_ack=0, state IDLE, all slots 0, counter 1.
